// File: rtl/pomdp_env_pkg.sv
// Shared types and constants for the PBVI environment responder.
package pomdp_env_pkg;

    localparam int PW_DEF    = 16;
    localparam int NUM_ACT   = 3;
    localparam int NUM_STATE = 2;
    localparam int NUM_OBS   = 2;

    typedef logic [1:0]        action_t;
    typedef logic              state_t;
    typedef logic [PW_DEF-1:0] prob_t;

    localparam action_t ACT_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRANS = 2'd1,
        ST_OBS   = 2'd2,
        ST_RESP  = 2'd3
    } fsm_t;

    // Illegal actions are folded onto row 0 so table indexing stays in range.
    function automatic action_t safe_act(input action_t a);
        return (a == ACT_ILLEGAL) ? 2'd0 : a;
    endfunction

endpackage

// File: rtl/pomdp_bin_sampler.sv
// Binary outcome sampler: index 0 when the draw is strictly below p, else index 1.
module pomdp_bin_sampler #(
    parameter int W = 16
) (
    input  logic [W-1:0] p_i,
    input  logic [W-1:0] r_i,
    output logic         sel_o
);

    assign sel_o = (r_i < p_i) ? 1'b0 : 1'b1;

endmodule

// File: rtl/pomdp_env_responder.sv
// Environment side of the agent/environment step handshake for the PBVI simulation.
// Optional episode horizon limit is enabled by defining POMDP_ENV_HORIZON_EN.
module pomdp_env_responder
    import pomdp_env_pkg::*;
#(
    parameter int PW      = 16,
    parameter int RW      = 16,
    parameter int AW      = 32,
    parameter int HORIZON = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            init_state,
    input  logic [PW-1:0]                   rand0,
    input  logic [PW-1:0]                   rand1,
    input  logic [2:0][1:0][1:0][PW-1:0]    trans,
    input  logic [2:0][1:0][1:0][PW-1:0]    observe,
    input  logic [2:0][1:0][RW-1:0]         vec_reward,
    input  logic                            act_valid,
    output logic                            act_ready,
    input  logic [1:0]                      act,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_obs,
    output logic                            rsp_state,
    output logic [RW-1:0]                   rsp_reward,
    output logic                            rsp_err,
    output logic                            cur_state,
    output logic [AW-1:0]                   acc_reward,
    output logic [15:0]                     step_cnt,
    output logic                            done
);

    fsm_t          fsm_q, fsm_d;
    action_t       act_q, act_d;
    logic [PW-1:0] rand1_q, rand1_d;
    state_t        next_q, next_d;
    logic [RW-1:0] reward_q, reward_d;
    state_t        cur_state_q, cur_state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [15:0]   step_q, step_d;
    logic          rsp_obs_q, rsp_obs_d;
    state_t        rsp_state_q, rsp_state_d;
    logic [RW-1:0] rsp_reward_q, rsp_reward_d;
    logic          rsp_err_q, rsp_err_d;

    logic          illegal;
    action_t       a_idx;
    logic          trans_sel;
    logic          obs_sel;

    assign illegal = (act_q == ACT_ILLEGAL);
    assign a_idx   = safe_act(act_q);

    pomdp_bin_sampler #(.W(PW)) u_trans_sampler (
        .p_i   (trans[a_idx][cur_state_q][0]),
        .r_i   (rand1_q),
        .sel_o (trans_sel)
    );

    pomdp_bin_sampler #(.W(PW)) u_obs_sampler (
        .p_i   (observe[a_idx][next_q][0]),
        .r_i   (rand0),
        .sel_o (obs_sel)
    );

`ifdef POMDP_ENV_HORIZON_EN
    logic done_q, done_d;
    assign act_ready = (fsm_q == ST_IDLE) && !done_q;
    assign done      = done_q;
`else
    assign act_ready = (fsm_q == ST_IDLE);
    assign done      = 1'b0;
`endif

    always_comb begin
        fsm_d        = fsm_q;
        act_d        = act_q;
        rand1_d      = rand1_q;
        next_d       = next_q;
        reward_d     = reward_q;
        cur_state_d  = cur_state_q;
        acc_d        = acc_q;
        step_d       = step_q;
        rsp_obs_d    = rsp_obs_q;
        rsp_state_d  = rsp_state_q;
        rsp_reward_d = rsp_reward_q;
        rsp_err_d    = rsp_err_q;
`ifdef POMDP_ENV_HORIZON_EN
        done_d       = done_q;
`endif

        case (fsm_q)
            ST_IDLE: begin
                if (act_valid && act_ready) begin
                    act_d   = act;
                    rand1_d = rand1;
                    fsm_d   = ST_TRANS;
                end
            end
            ST_TRANS: begin
                next_d   = illegal ? cur_state_q : trans_sel;
                reward_d = illegal ? '0 : vec_reward[a_idx][cur_state_q];
                fsm_d    = ST_OBS;
            end
            ST_OBS: begin
                rsp_obs_d    = illegal ? 1'b0 : obs_sel;
                rsp_state_d  = next_q;
                rsp_reward_d = reward_q;
                rsp_err_d    = illegal;
                fsm_d        = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    // An illegal step carries rsp_state==cur_state and zero reward,
                    // so the normal commit path leaves state and total unchanged.
                    cur_state_d = rsp_state_q;
                    acc_d       = acc_q + AW'(rsp_reward_q);
                    step_d      = step_q + 16'd1;
`ifdef POMDP_ENV_HORIZON_EN
                    if (step_d == 16'(HORIZON)) begin
                        done_d = 1'b1;
                    end
`endif
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase

        if (start) begin
            cur_state_d = init_state;
            acc_d       = '0;
            step_d      = '0;
            fsm_d       = ST_IDLE;
            act_d       = act_q;
            rand1_d     = rand1_q;
`ifdef POMDP_ENV_HORIZON_EN
            done_d      = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q        <= ST_IDLE;
            act_q        <= '0;
            rand1_q      <= '0;
            next_q       <= 1'b0;
            reward_q     <= '0;
            cur_state_q  <= 1'b0;
            acc_q        <= '0;
            step_q       <= '0;
            rsp_obs_q    <= 1'b0;
            rsp_state_q  <= 1'b0;
            rsp_reward_q <= '0;
            rsp_err_q    <= 1'b0;
`ifdef POMDP_ENV_HORIZON_EN
            done_q       <= 1'b0;
`endif
        end else begin
            fsm_q        <= fsm_d;
            act_q        <= act_d;
            rand1_q      <= rand1_d;
            next_q       <= next_d;
            reward_q     <= reward_d;
            cur_state_q  <= cur_state_d;
            acc_q        <= acc_d;
            step_q       <= step_d;
            rsp_obs_q    <= rsp_obs_d;
            rsp_state_q  <= rsp_state_d;
            rsp_reward_q <= rsp_reward_d;
            rsp_err_q    <= rsp_err_d;
`ifdef POMDP_ENV_HORIZON_EN
            done_q       <= done_d;
`endif
        end
    end

    assign rsp_valid  = (fsm_q == ST_RESP);
    assign rsp_obs    = rsp_obs_q;
    assign rsp_state  = rsp_state_q;
    assign rsp_reward = rsp_reward_q;
    assign rsp_err    = rsp_err_q;
    assign cur_state  = cur_state_q;
    assign acc_reward = acc_q;
    assign step_cnt   = step_q;

endmodule

// File: tb/tb_pomdp_env_responder.sv
// Self-checking bench for pomdp_env_responder; scoreboard of expected step responses.
module tb_pomdp_env_responder;

    localparam int PW = 16;
    localparam int RW = 16;
    localparam int AW = 32;
`ifdef POMDP_ENV_HORIZON_EN
    localparam int HZ = 3;
`else
    localparam int HZ = 64;
`endif

    logic                         clk;
    logic                         rst;
    logic                         start;
    logic                         init_state;
    logic [PW-1:0]                rand0;
    logic [PW-1:0]                rand1;
    logic [2:0][1:0][1:0][PW-1:0] trans;
    logic [2:0][1:0][1:0][PW-1:0] observe;
    logic [2:0][1:0][RW-1:0]      vec_reward;
    logic                         act_valid;
    logic                         act_ready;
    logic [1:0]                   act;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic                         rsp_obs;
    logic                         rsp_state;
    logic [RW-1:0]                rsp_reward;
    logic                         rsp_err;
    logic                         cur_state;
    logic [AW-1:0]                acc_reward;
    logic [15:0]                  step_cnt;
    logic                         done;

    pomdp_env_responder #(.PW(PW), .RW(RW), .AW(AW), .HORIZON(HZ)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .init_state (init_state),
        .rand0      (rand0),
        .rand1      (rand1),
        .trans      (trans),
        .observe    (observe),
        .vec_reward (vec_reward),
        .act_valid  (act_valid),
        .act_ready  (act_ready),
        .act        (act),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_obs    (rsp_obs),
        .rsp_state  (rsp_state),
        .rsp_reward (rsp_reward),
        .rsp_err    (rsp_err),
        .cur_state  (cur_state),
        .acc_reward (acc_reward),
        .step_cnt   (step_cnt),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          st;
        logic          obs;
        logic [RW-1:0] rw;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    int            pass_cnt  = 0;
    int            total_cnt = 0;
    logic          m_cur;
    logic [AW-1:0] m_acc;
    logic [15:0]   m_cnt;
    logic          m_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic s);
        start      = 1'b1;
        init_state = s;
        tick();
        start  = 1'b0;
        m_cur  = s;
        m_acc  = '0;
        m_cnt  = '0;
        m_done = 1'b0;
    endtask

    task automatic do_step(input logic [1:0] a, input logic [PW-1:0] r1,
                           input logic [PW-1:0] r0, input int hold);
        exp_t e;
        exp_t p;
        if (m_done) do_start(m_cur);
        if (a == 2'd3) begin
            e.st = m_cur; e.obs = 1'b0; e.rw = '0; e.err = 1'b1;
        end else begin
            e.st  = (r1 < trans[a][m_cur][0]) ? 1'b0 : 1'b1;
            e.obs = (r0 < observe[a][e.st][0]) ? 1'b0 : 1'b1;
            e.rw  = vec_reward[a][m_cur];
            e.err = 1'b0;
        end
        sb.push_back(e);
        rand0 = r0; rand1 = r1; act = a; act_valid = 1'b1;
        total_cnt++; if (act_ready !== 1'b1) $display("FAIL step_ready act_ready=%0b exp=1", act_ready); else pass_cnt++;
        tick();
        act_valid = 1'b0; act = 2'($urandom_range(0, 3)); rand1 = PW'($urandom);
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL lat_n1 rsp_valid=%0b exp=0", rsp_valid); else pass_cnt++;
        tick();
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL lat_n2 rsp_valid=%0b exp=0", rsp_valid); else pass_cnt++;
        tick();
        total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL lat_n3 rsp_valid=%0b exp=1", rsp_valid); else pass_cnt++;
        p = sb.pop_front();
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
                tick();
                rand0 = PW'($urandom);
                total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL hold_valid rsp_valid=%0b exp=1", rsp_valid); else pass_cnt++;
                total_cnt++; if (act_ready !== 1'b0) $display("FAIL hold_ready act_ready=%0b exp=0", act_ready); else pass_cnt++;
            end
            total_cnt++; if (rsp_state !== p.st) $display("FAIL rsp_state got=%0b exp=%0b", rsp_state, p.st); else pass_cnt++;
            total_cnt++; if (rsp_obs !== p.obs) $display("FAIL rsp_obs got=%0b exp=%0b", rsp_obs, p.obs); else pass_cnt++;
            total_cnt++; if (rsp_reward !== p.rw) $display("FAIL rsp_reward got=%0d exp=%0d", rsp_reward, p.rw); else pass_cnt++;
            total_cnt++; if (rsp_err !== p.err) $display("FAIL rsp_err got=%0b exp=%0b", rsp_err, p.err); else pass_cnt++;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        m_cur = p.st;
        m_acc = m_acc + AW'(p.rw);
        m_cnt = m_cnt + 16'd1;
`ifdef POMDP_ENV_HORIZON_EN
        if (m_cnt == 16'(HZ)) m_done = 1'b1;
`endif
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL commit_valid rsp_valid=%0b exp=0", rsp_valid); else pass_cnt++;
        total_cnt++; if (cur_state !== m_cur) $display("FAIL commit_state got=%0b exp=%0b", cur_state, m_cur); else pass_cnt++;
        total_cnt++; if (acc_reward !== m_acc) $display("FAIL commit_acc got=%0d exp=%0d", acc_reward, m_acc); else pass_cnt++;
        total_cnt++; if (step_cnt !== m_cnt) $display("FAIL commit_cnt got=%0d exp=%0d", step_cnt, m_cnt); else pass_cnt++;
        total_cnt++; if (done !== m_done) $display("FAIL commit_done got=%0b exp=%0b", done, m_done); else pass_cnt++;
        $display("step act=%0d r1=%h r0=%h hold=%0d -> state=%0b obs=%0b rew=%0d err=%0b acc=%0d cnt=%0d",
                 a, r1, r0, hold, p.st, p.obs, p.rw, p.err, m_acc, m_cnt);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; init_state = 1'b0; act_valid = 1'b0; act = '0;
        rsp_ready = 1'b0; rand0 = '0; rand1 = '0;
        trans = '0; observe = '0; vec_reward = '0;
        repeat (3) tick();
        rst = 1'b0;
        m_cur = 1'b0; m_acc = '0; m_cnt = '0; m_done = 1'b0;
        total_cnt++; if (act_ready !== 1'b1) $display("FAIL reset_ready got=%0b exp=1", act_ready); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", rsp_valid); else pass_cnt++;
        total_cnt++; if (cur_state !== 1'b0) $display("FAIL reset_state got=%0b exp=0", cur_state); else pass_cnt++;
        total_cnt++; if (acc_reward !== '0) $display("FAIL reset_acc got=%0d exp=0", acc_reward); else pass_cnt++;
        total_cnt++; if (step_cnt !== '0) $display("FAIL reset_cnt got=%0d exp=0", step_cnt); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else pass_cnt++;
        total_cnt++; if ({rsp_obs, rsp_state, rsp_err, rsp_reward} !== '0) $display("FAIL reset_rsp got=%h exp=0", {rsp_obs, rsp_state, rsp_err, rsp_reward}); else pass_cnt++;
        $display("reset done");
    endtask

    task automatic test_transition();
        do_start(1'b0);
        trans[1][0][0] = 16'h8000;
        do_step(2'd1, 16'h7FFF, 16'h0000, 0);
        total_cnt++; if (cur_state !== 1'b0) $display("FAIL trans_below got=%0b exp=0", cur_state); else pass_cnt++;
        do_start(1'b0);
        do_step(2'd1, 16'h8000, 16'h0000, 0);
        total_cnt++; if (cur_state !== 1'b1) $display("FAIL trans_equal got=%0b exp=1", cur_state); else pass_cnt++;
    endtask

    task automatic test_obs_reward();
        do_start(1'b0);
        trans[0][0][0]   = 16'h0000;
        observe[0][1][0] = 16'h0000;
        vec_reward[0][0] = 16'd5;
        do_step(2'd0, PW'($urandom), PW'($urandom), 0);
        total_cnt++; if (acc_reward !== 32'd5) $display("FAIL obsrew_acc got=%0d exp=5", acc_reward); else pass_cnt++;
        total_cnt++; if (cur_state !== 1'b1) $display("FAIL obsrew_state got=%0b exp=1", cur_state); else pass_cnt++;
        total_cnt++; if (step_cnt !== 16'd1) $display("FAIL obsrew_cnt got=%0d exp=1", step_cnt); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_start(1'b1);
        vec_reward[2][1] = 16'd9;
        trans[2][1][0]   = 16'h4000;
        observe[2][0][0] = 16'hC000;
        observe[2][1][0] = 16'h2000;
        do_step(2'd2, 16'h1234, 16'h9000, 10);
        total_cnt++; if (step_cnt !== 16'd1) $display("FAIL bp_cnt got=%0d exp=1", step_cnt); else pass_cnt++;
    endtask

    task automatic test_illegal();
        do_start(1'b1);
        vec_reward = '1;
        do_step(2'd3, 16'h0000, 16'h0000, 1);
        total_cnt++; if (cur_state !== 1'b1) $display("FAIL illegal_state got=%0b exp=1", cur_state); else pass_cnt++;
        total_cnt++; if (step_cnt !== 16'd1) $display("FAIL illegal_cnt got=%0d exp=1", step_cnt); else pass_cnt++;
        total_cnt++; if (acc_reward !== '0) $display("FAIL illegal_acc got=%0d exp=0", acc_reward); else pass_cnt++;
    endtask

    task automatic test_boundary();
        do_start(1'b0);
        trans[2][0][0]   = 16'hFFFF;
        observe[2][1][0] = 16'hFFFF;
        observe[2][0][0] = 16'hFFFF;
        do_step(2'd2, 16'hFFFF, 16'hFFFF, 0);
        total_cnt++; if (cur_state !== 1'b1) $display("FAIL bnd_max_draw got=%0b exp=1", cur_state); else pass_cnt++;
        do_start(1'b0);
        do_step(2'd2, 16'hFFFE, 16'hFFFE, 0);
        total_cnt++; if (cur_state !== 1'b0) $display("FAIL bnd_below_max got=%0b exp=0", cur_state); else pass_cnt++;
    endtask

    task automatic test_mid_start();
        do_start(1'b0);
        vec_reward[0][0] = 16'd7;
        do_step(2'd0, PW'($urandom), PW'($urandom), 0);
        act = 2'd1; act_valid = 1'b1;
        tick();
        act_valid = 1'b0;
        tick();
        start = 1'b1; init_state = 1'b1;
        tick();
        start = 1'b0;
        m_cur = 1'b1; m_acc = '0; m_cnt = '0; m_done = 1'b0;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL mid_valid got=%0b exp=0", rsp_valid); else pass_cnt++;
        total_cnt++; if (cur_state !== 1'b1) $display("FAIL mid_state got=%0b exp=1", cur_state); else pass_cnt++;
        total_cnt++; if (acc_reward !== '0) $display("FAIL mid_acc got=%0d exp=0", acc_reward); else pass_cnt++;
        total_cnt++; if (step_cnt !== '0) $display("FAIL mid_cnt got=%0d exp=0", step_cnt); else pass_cnt++;
        total_cnt++; if (act_ready !== 1'b1) $display("FAIL mid_ready got=%0b exp=1", act_ready); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick();
            total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL mid_quiet got=%0b exp=0", rsp_valid); else pass_cnt++;
        end
        $display("mid-step start discarded step, cur_state=%0b", cur_state);
    endtask

    task automatic test_start_collide();
        act = 2'd0; act_valid = 1'b1; start = 1'b1; init_state = 1'b0;
        tick();
        act_valid = 1'b0; start = 1'b0;
        m_cur = 1'b0; m_acc = '0; m_cnt = '0; m_done = 1'b0;
        total_cnt++; if (act_ready !== 1'b1) $display("FAIL collide_ready got=%0b exp=1", act_ready); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL collide_quiet got=%0b exp=0", rsp_valid); else pass_cnt++;
        end
        $display("start+action collision: action dropped");
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 3; a++)
            for (int s = 0; s < 2; s++) begin
                trans[a][s][0]   = PW'($urandom);
                observe[a][s][0] = PW'($urandom);
                vec_reward[a][s] = RW'($urandom_range(0, 1000));
            end
        do_start(1'b0);
        for (int i = 0; i < 10; i++)
            do_step(2'($urandom_range(0, 3)), PW'($urandom), PW'($urandom), $urandom_range(0, 2));
    endtask

`ifdef POMDP_ENV_HORIZON_EN
    task automatic test_horizon();
        do_start(1'b0);
        for (int i = 0; i < 3; i++)
            do_step(2'($urandom_range(0, 2)), PW'($urandom), PW'($urandom), 0);
        total_cnt++; if (done !== 1'b1) $display("FAIL hz_done got=%0b exp=1", done); else pass_cnt++;
        total_cnt++; if (act_ready !== 1'b0) $display("FAIL hz_ready got=%0b exp=0", act_ready); else pass_cnt++;
        do_start(1'b0);
        total_cnt++; if (done !== 1'b0) $display("FAIL hz_clear got=%0b exp=0", done); else pass_cnt++;
        total_cnt++; if (act_ready !== 1'b1) $display("FAIL hz_ready2 got=%0b exp=1", act_ready); else pass_cnt++;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_transition();
        test_obs_reward();
        test_backpressure();
        test_illegal();
        test_boundary();
        test_mid_start();
        test_start_collide();
        test_back_to_back();
`ifdef POMDP_ENV_HORIZON_EN
        test_horizon();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
